// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, types and constants for the operand-fetch slice.
package cpu_pkg;
    localparam int RWIDTH = 6;
    localparam int DWIDTH = 32;
    typedef logic [RWIDTH-1:0] reg_addr_t;
    typedef logic [DWIDTH-1:0] word_t;
    localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with a running popcount.
module regfile_scoreboard
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  reg_addr_t        set_addr,
    input  logic             clr_en,
    input  reg_addr_t        clr_addr,
    input  reg_addr_t        look1_addr,
    input  reg_addr_t        look2_addr,
    output logic             look1_busy,
    output logic             look2_busy,
    output logic [RWIDTH:0]  count
);
    logic [2**RWIDTH-1:0] busy_q, busy_d;
    logic [RWIDTH:0]      cnt_q, cnt_d;
    logic                 set_new, clr_eff;

    // A set on the same register as a clear wins, so the clear is suppressed.
    always_comb begin
        set_new = set_en && set_addr != ZERO_REG && !busy_q[set_addr];
        clr_eff = clr_en && clr_addr != ZERO_REG && busy_q[clr_addr]
                  && !(set_en && set_addr == clr_addr);
        busy_d = busy_q;
        if (clr_eff) busy_d[clr_addr] = 1'b0;
        if (set_en && set_addr != ZERO_REG) busy_d[set_addr] = 1'b1;
        cnt_d = cnt_q + (RWIDTH+1)'(set_new) - (RWIDTH+1)'(clr_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign look1_busy = busy_q[look1_addr];
    assign look2_busy = busy_q[look2_addr];
    assign count      = cnt_q;
endmodule

// File: rtl/operand_fetch_32bit.sv
// operand_fetch_32bit: issue handshake, writeback bypass and registered
// operand stage in front of execute, gated by a register scoreboard.
module operand_fetch_32bit
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  reg_addr_t        issue_rs1,
    input  reg_addr_t        issue_rs2,
    input  reg_addr_t        issue_rd,
    input  logic             issue_wr,
    output reg_addr_t        ra1,
    output reg_addr_t        ra2,
    input  word_t            rd1,
    input  word_t            rd2,
    input  logic             wb_we,
    input  reg_addr_t        wb_wa,
    input  word_t            wb_wd,
    output logic             op_valid,
    input  logic             op_ready,
    output word_t            op_a,
    output word_t            op_b,
    output reg_addr_t        op_rd,
    output logic             op_wr,
    output logic [RWIDTH:0]  pending_cnt
);
    logic      busy1, busy2, byp1, byp2, accept;
    word_t     opa_d, opb_d;
    logic      op_valid_q, op_wr_q;
    word_t     op_a_q, op_b_q;
    reg_addr_t op_rd_q;

    assign ra1 = issue_rs1;
    assign ra2 = issue_rs2;

    regfile_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en     (accept && issue_wr),
        .set_addr   (issue_rd),
        .clr_en     (wb_we),
        .clr_addr   (wb_wa),
        .look1_addr (issue_rs1),
        .look2_addr (issue_rs2),
        .look1_busy (busy1),
        .look2_busy (busy2),
        .count      (pending_cnt)
    );

    always_comb begin
        byp1        = wb_we && wb_wa == issue_rs1;
        byp2        = wb_we && wb_wa == issue_rs2;
        opa_d       = issue_rs1 == ZERO_REG ? '0 : byp1 ? wb_wd : rd1;
        opb_d       = issue_rs2 == ZERO_REG ? '0 : byp2 ? wb_wd : rd2;
        issue_ready = !(busy1 && !byp1) && !(busy2 && !byp2) && (!op_valid_q || op_ready);
        accept      = issue_valid && issue_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_rd_q    <= '0;
            op_wr_q    <= 1'b0;
        end else if (accept) begin
            op_valid_q <= 1'b1;
            op_a_q     <= opa_d;
            op_b_q     <= opb_d;
            op_rd_q    <= issue_rd;
            op_wr_q    <= issue_wr;
        end else if (op_ready) begin
            op_valid_q <= 1'b0;
        end
    end

    assign op_valid = op_valid_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_rd    = op_rd_q;
    assign op_wr    = op_wr_q;
endmodule

// File: tb/tb_operand_fetch_32bit.sv
// tb_operand_fetch_32bit: directed checks of handshake, bypass, scoreboard and reset.
module tb_operand_fetch_32bit;
    import cpu_pkg::*;
    logic            clk = 1'b0;
    logic            rst, issue_valid, issue_ready, issue_wr, wb_we;
    logic            op_valid, op_ready, op_wr;
    reg_addr_t       issue_rs1, issue_rs2, issue_rd, ra1, ra2, wb_wa, op_rd;
    word_t           rd1, rd2, wb_wd, op_a, op_b;
    logic [RWIDTH:0] pending_cnt;
    int              compared = 0;
    int              mismatched = 0;

    always #5 clk = ~clk;

    operand_fetch_32bit dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_wr(issue_wr),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_rd(op_rd), .op_wr(op_wr), .pending_cnt(pending_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input reg_addr_t s1, input reg_addr_t s2, input reg_addr_t d, input logic w);
        issue_valid = 1'b1;
        issue_rs1 = s1;
        issue_rs2 = s2;
        issue_rd = d;
        issue_wr = w;
        #1;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_wr = 0;
        rd1 = 0; rd2 = 0; wb_we = 0; wb_wa = 0; wb_wd = 0; op_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_op_valid", 32'(op_valid), 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_op_rd", 32'(op_rd), 0);
        check("rst_op_wr", 32'(op_wr), 0);
        check("rst_pending", 32'(pending_cnt), 0);

        // 1: basic issue
        rd1 = 32'h11; rd2 = 32'h22;
        issue(3, 4, 5, 1);
        check("t1_ra1", 32'(ra1), 3);
        check("t1_ra2", 32'(ra2), 4);
        check("t1_ready", 32'(issue_ready), 1);
        tick();
        check("t1_op_valid", 32'(op_valid), 1);
        check("t1_op_a", op_a, 32'h11);
        check("t1_op_b", op_b, 32'h22);
        check("t1_op_rd", 32'(op_rd), 5);
        check("t1_op_wr", 32'(op_wr), 1);
        check("t1_pending", 32'(pending_cnt), 1);

        // 2: RAW stall then bypass
        issue(5, 0, 6, 0);
        check("t2_blocked", 32'(issue_ready), 0);
        tick();
        check("t2_drain_valid", 32'(op_valid), 0);
        check("t2_drain_op_a", op_a, 32'h11);
        check("t2_still_blocked", 32'(issue_ready), 0);
        wb_we = 1; wb_wa = 5; wb_wd = 32'hDEADBEEF; #1;
        check("t2_bypass_ready", 32'(issue_ready), 1);
        tick();
        wb_we = 0;
        check("t2_op_valid", 32'(op_valid), 1);
        check("t2_op_a", op_a, 32'hDEADBEEF);
        check("t2_op_b", op_b, 0);
        check("t2_op_rd", 32'(op_rd), 6);
        check("t2_pending", 32'(pending_cnt), 0);

        // 3: register zero reads as zero, rd=0 never busy
        rd1 = 32'hFFFFFFFF; rd2 = 32'hFFFFFFFF;
        issue(0, 0, 0, 1);
        tick();
        check("t3_op_a", op_a, 0);
        check("t3_op_b", op_b, 0);
        check("t3_op_wr", 32'(op_wr), 1);
        check("t3_pending", 32'(pending_cnt), 0);

        // 4: execute stall holds outputs, then back-to-back
        op_ready = 0; rd1 = 32'h100; rd2 = 32'h200;
        issue(1, 2, 8, 1);
        for (int i = 0; i < 3; i++) begin
            check("t4_stall_ready", 32'(issue_ready), 0);
            tick();
            check("t4_hold_valid", 32'(op_valid), 1);
            check("t4_hold_op_a", op_a, 0);
            check("t4_hold_op_rd", 32'(op_rd), 0);
        end
        op_ready = 1; #1;
        check("t4_release_ready", 32'(issue_ready), 1);
        tick();
        check("t4_op_valid", 32'(op_valid), 1);
        check("t4_op_a", op_a, 32'h100);
        check("t4_op_b", op_b, 32'h200);
        check("t4_op_rd", 32'(op_rd), 8);
        check("t4_pending", 32'(pending_cnt), 1);
        rd1 = 32'h300; rd2 = 32'h400;
        issue(10, 11, 9, 1);
        check("t4_b2b_ready", 32'(issue_ready), 1);
        tick();
        check("t4_b2b_valid", 32'(op_valid), 1);
        check("t4_b2b_op_a", op_a, 32'h300);
        check("t4_b2b_op_rd", 32'(op_rd), 9);
        check("t4_b2b_pending", 32'(pending_cnt), 2);

        // drain scoreboard; writeback to non-busy register has no effect
        issue_valid = 0; wb_we = 1; wb_wa = 8; tick();
        check("wb8_pending", 32'(pending_cnt), 1);
        check("wb8_drain_valid", 32'(op_valid), 0);
        wb_wa = 9; tick();
        check("wb9_pending", 32'(pending_cnt), 0);
        wb_wa = 20; tick();
        check("wb_idle_pending", 32'(pending_cnt), 0);

        // 5: set and clear on same register, set wins
        wb_wa = 7; wb_wd = 32'h55;
        issue(0, 0, 7, 1);
        tick();
        wb_we = 0;
        check("t5_pending", 32'(pending_cnt), 1);
        issue(7, 0, 0, 0);
        check("t5_busy7_blocks", 32'(issue_ready), 0);

        // 6: reset mid-operation
        issue(0, 0, 12, 1);
        tick();
        check("t6_pending2", 32'(pending_cnt), 2);
        op_ready = 0; issue_valid = 0; rst = 1;
        tick();
        rst = 0;
        check("t6_rst_valid", 32'(op_valid), 0);
        check("t6_rst_pending", 32'(pending_cnt), 0);
        check("t6_rst_op_rd", 32'(op_rd), 0);
        rd1 = 32'h77; rd2 = 32'hCC; op_ready = 1;
        issue(7, 12, 0, 0);
        check("t6_ready", 32'(issue_ready), 1);
        tick();
        issue_valid = 0;
        check("t6_op_valid", 32'(op_valid), 1);
        check("t6_op_a", op_a, 32'h77);
        check("t6_op_b", op_b, 32'hCC);
        check("t6_pending", 32'(pending_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
